// File: rtl/tile_raster_assembler.sv
// tile_raster_assembler: rebuilds a raster frame from tile-ordered pixels, then streams it out in raster order
module tile_raster_assembler #(
   parameter int DATA_WIDTH  = 8,
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 16,
   parameter int TILE_WIDTH  = 16,
   parameter int TILE_HEIGHT = 16
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic [DATA_WIDTH-1:0] iData,
   input  logic                  iValid,
   output logic                  oReady,
   output logic [DATA_WIDTH-1:0] oData,
   output logic                  oValid,
   input  logic                  iReady,
   output logic                  oLast,
   output logic                  oFrameDone
);
   localparam int TilesX = IMG_WIDTH / TILE_WIDTH;
   localparam int TilesY = IMG_HEIGHT / TILE_HEIGHT;
   localparam int Depth  = IMG_WIDTH * IMG_HEIGHT;
   localparam int AddrW  = Depth > 1 ? $clog2(Depth) : 1;
   localparam int ColW   = TILE_WIDTH > 1 ? $clog2(TILE_WIDTH) : 1;
   localparam int RowW   = TILE_HEIGHT > 1 ? $clog2(TILE_HEIGHT) : 1;
   localparam int TxW    = TilesX > 1 ? $clog2(TilesX) : 1;
   localparam int TyW    = TilesY > 1 ? $clog2(TilesY) : 1;
   // read counter carries one extra bit so it can step past the last address without wrapping
   localparam logic [AddrW:0] LastRd = (AddrW+1)'(Depth - 1);

   typedef enum logic {Fill, Drain} stateType;

   stateType              state;
   logic [DATA_WIDTH-1:0] mem [Depth];
   logic [ColW-1:0]       col;
   logic [RowW-1:0]       row;
   logic [TxW-1:0]        tileX;
   logic [TyW-1:0]        tileY;
   logic [AddrW:0]        rdAddr;
   logic [AddrW-1:0]      wrAddr;
   logic                  wrEn, rdEn, colMax, rowMax, txMax, tyMax;

   assign colMax = col == ColW'(TILE_WIDTH - 1);
   assign rowMax = row == RowW'(TILE_HEIGHT - 1);
   assign txMax  = tileX == TxW'(TilesX - 1);
   assign tyMax  = tileY == TyW'(TilesY - 1);
   assign wrEn   = state == Fill && iValid && oReady;
   assign rdEn   = state == Drain && rdAddr <= LastRd && (!oValid || iReady);
   assign wrAddr = AddrW'((int'(tileY) * TILE_HEIGHT + int'(row)) * IMG_WIDTH
                          + int'(tileX) * TILE_WIDTH + int'(col));

   // frame buffer write port; contents survive reset
   always_ff @(posedge iClk) begin
      if (wrEn) mem[wrAddr] <= iData;
   end

   // fill/drain control with tile counters, read counter and registered stream outputs
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state      <= Fill;
         col        <= '0;
         row        <= '0;
         tileX      <= '0;
         tileY      <= '0;
         rdAddr     <= '0;
         oReady     <= 1'b1;
         oValid     <= 1'b0;
         oData      <= '0;
         oLast      <= 1'b0;
         oFrameDone <= 1'b0;
      end else begin
         oFrameDone <= 1'b0;
         case (state)
            Fill: if (wrEn) begin
               col <= colMax ? '0 : col + 1'b1;
               if (colMax) row <= rowMax ? '0 : row + 1'b1;
               if (colMax && rowMax) tileX <= txMax ? '0 : tileX + 1'b1;
               if (colMax && rowMax && txMax) tileY <= tyMax ? '0 : tileY + 1'b1;
               if (colMax && rowMax && txMax && tyMax) begin
                  state  <= Drain;
                  oReady <= 1'b0;
                  rdAddr <= '0;
               end
            end
            Drain: if (rdEn) begin
               oData  <= mem[rdAddr[AddrW-1:0]];
               oValid <= 1'b1;
               oLast  <= rdAddr == LastRd;
               rdAddr <= rdAddr + 1'b1;
            end else if (iReady) begin
               oValid <= 1'b0;
               if (oValid && oLast) begin
                  state      <= Fill;
                  oReady     <= 1'b1;
                  oLast      <= 1'b0;
                  rdAddr     <= '0;
                  oFrameDone <= 1'b1;
               end
            end
            default: state <= Fill;
         endcase
      end
   end
endmodule

// File: tb/tb_tile_raster_assembler.sv
// tb_tile_raster_assembler: scoreboard bench feeding tile-ordered frames and checking the raster stream
module tb_tile_raster_assembler;
   localparam int N = 512;

   logic       iClk = 1'b0, iRst = 1'b0, iValid = 1'b0, iReady = 1'b0;
   logic       oReady, oValid, oLast, oFrameDone;
   logic [7:0] iData = 8'h00, oData;

   tile_raster_assembler dut (
      .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .oReady(oReady),
      .oData(oData), .oValid(oValid), .iReady(iReady), .oLast(oLast), .oFrameDone(oFrameDone)
   );

   always #5 iClk = ~iClk;

   int errCnt = 0, chkCnt = 0, cyc = 0;
   int feedIdx, outIdx, mode, gapMode, stallAt, stallCnt, rstIn, rstOut;
   int lastWrCyc, lastOutCyc, doneCnt;
   bit done, aborted;
   logic [7:0] modelBuf [N];
   logic [7:0] gotFrame [N];
   logic [7:0] refFrame [N];
   logic [7:0] expQ [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] pixVal(input int idx);
      return mode != 0 ? 8'(255 - idx % 256) : 8'(idx % 256);
   endfunction

   function automatic int rasterOf(input int idx);
      int tile = idx / 256, w = idx % 256;
      return ((tile / 2) * 16 + w / 16) * 32 + (tile % 2) * 16 + w % 16;
   endfunction

   task automatic doReset();
      iRst = 1'b1; iValid = 1'b0; iReady = 1'b1;
      #1;
      check("rst_oValid", oValid, 0);
      check("rst_oData", oData, 0);
      check("rst_oLast", oLast, 0);
      check("rst_oFrameDone", oFrameDone, 0);
      @(negedge iClk);
      iRst = 1'b0;
      #1;
      check("rst_oReady", oReady, 1);
   endtask

   task automatic step();
      logic [7:0] exp;
      @(negedge iClk);
      cyc++;
      if (oFrameDone) doneCnt++;
      if (cyc == lastWrCyc + 1) check("lat_oReady", oReady, 0);
      if (cyc == lastWrCyc + 2) begin
         check("lat_oValid", oValid, 1);
         check("lat_oData", oData, expQ[0]);
      end
      if (cyc == lastOutCyc + 1) begin
         check("done_pulse", oFrameDone, 1);
         check("done_oValid", oValid, 0);
         check("done_oReady", oReady, 1);
         done = 1;
      end
      if ((rstIn >= 0 && feedIdx == rstIn) || (rstOut >= 0 && outIdx == rstOut)) begin
         doReset();
         aborted = 1;
         return;
      end
      if (feedIdx < N) begin
         iValid = gapMode != 0 ? 1'($urandom % 2) : 1'b1;
         iData  = iValid ? pixVal(feedIdx) : 8'($urandom);
      end else begin
         iValid = (gapMode != 0 && !oReady) ? 1'($urandom % 2) : 1'b0;
         iData  = 8'($urandom);
      end
      iReady = 1'b1;
      if (stallAt >= 0 && outIdx == stallAt && stallCnt < 5) begin
         iReady = 1'b0;
         stallCnt++;
         check("stall_valid", oValid, 1);
         check("stall_data", oData, expQ[0]);
      end
      if (oValid && iReady) begin
         check("queue_nonempty", expQ.size() > 0, 1);
         if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            check("data", oData, exp);
            check("last", oLast, outIdx == N - 1);
         end
         if (outIdx < N) gotFrame[outIdx] = oData;
         if (outIdx == N - 1) lastOutCyc = cyc;
         outIdx++;
      end
      if (iValid && oReady && feedIdx < N) begin
         modelBuf[rasterOf(feedIdx)] = iData;
         feedIdx++;
         if (feedIdx == N) begin
            lastWrCyc = cyc;
            for (int i = 0; i < N; i++) expQ.push_back(modelBuf[i]);
         end
      end
   endtask

   task automatic runFrame(input int m, input int gap, input int stall, input int rIn, input int rOut);
      mode = m; gapMode = gap; stallAt = stall; stallCnt = 0; rstIn = rIn; rstOut = rOut;
      feedIdx = 0; outIdx = 0; doneCnt = 0; done = 0; aborted = 0;
      lastWrCyc = -10; lastOutCyc = -10;
      expQ.delete();
      for (int k = 0; k < 4000 && !done && !aborted; k++) step();
      if (!aborted) begin
         check("frame_done_seen", done, 1);
         check("transfers", outIdx, N);
         check("done_count", doneCnt, 1);
      end
   endtask

   initial begin
      int diffs;
      #1 iRst = 1'b1;
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      check("init_oValid", oValid, 0);
      check("init_oData", oData, 0);
      check("init_oLast", oLast, 0);
      check("init_oFrameDone", oFrameDone, 0);
      iRst = 1'b0;
      #1;
      check("init_oReady", oReady, 1);

      runFrame(0, 0, -1, -1, -1);
      check("in_order_0", gotFrame[0], 8'h00);
      check("in_order_15", gotFrame[15], 8'h0F);
      check("in_order_16", gotFrame[16], 8'h00);
      check("in_order_17", gotFrame[17], 8'h01);
      check("in_order_32", gotFrame[32], 8'h10);
      check("in_order_511", gotFrame[511], 8'hFF);
      for (int i = 0; i < N; i++) refFrame[i] = gotFrame[i];

      runFrame(0, 0, 100, -1, -1);
      check("stall_cycles", stallCnt, 5);

      runFrame(0, 1, -1, -1, -1);
      diffs = 0;
      for (int i = 0; i < N; i++) if (gotFrame[i] !== refFrame[i]) diffs++;
      check("gaps_vs_in_order", diffs, 0);

      runFrame(0, 0, -1, 300, -1);
      check("reset_in_hit", aborted, 1);
      runFrame(0, 0, -1, -1, -1);
      check("after_rst_in_17", gotFrame[17], 8'h01);

      runFrame(0, 0, -1, -1, 200);
      check("reset_out_hit", aborted, 1);
      runFrame(0, 0, -1, -1, -1);
      check("after_rst_out_32", gotFrame[32], 8'h10);

      runFrame(1, 0, -1, -1, -1);
      check("inv_0", gotFrame[0], 8'hFF);
      check("inv_16", gotFrame[16], 8'hFF);
      check("inv_511", gotFrame[511], 8'h00);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end
endmodule

// File: doc/tile_raster_assembler.md
Name: tile_raster_assembler

Overview:
- Inverse of the tile-reading BRAM front end: accepts pixels in tile order (tiles left-to-right, then top-to-bottom; row-major inside each tile).
- Writes each pixel into an internal frame buffer at its raster address.
- Once a full frame is stored, streams the frame out in raster order over a valid/ready interface.
- Sits after the processing path (CNN or bypass) and rebuilds a raster image for output.

Parameters:
- DATA_WIDTH, 8, pixel width.
- IMG_WIDTH, 32, frame width in pixels; must be a multiple of TILE_WIDTH.
- IMG_HEIGHT, 16, frame height in pixels; must be a multiple of TILE_HEIGHT.
- TILE_WIDTH, 16, tile width in pixels.
- TILE_HEIGHT, 16, tile height in pixels.

Ports:
- iClk  input  1  clock; all logic on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iData  input  DATA_WIDTH  tile-ordered input pixel.
- iValid  input  1  iData valid.
- oReady  output  1  block accepts input; a write occurs on iValid && oReady.
- oData  output  DATA_WIDTH  raster-ordered output pixel.
- oValid  output  1  oData valid.
- iReady  input  1  downstream accepts; a transfer occurs on oValid && iReady.
- oLast  output  1  high with the final raster pixel of the frame.
- oFrameDone  output  1  one-cycle pulse after the final output transfer.

Behaviour:
- Reset (async, iRst=1): state=FILL; all counters 0; oValid=0; oData=0; oLast=0; oFrameDone=0. oReady=1 once reset deasserts. Buffer contents are not cleared. Reset mid-FILL or mid-DRAIN discards the frame in progress; the next accepted pixel is tile 0, row 0, col 0.
- Buffer: IMG_WIDTH*IMG_HEIGHT entries of DATA_WIDTH bits; single write port, single read port; read latency 1 cycle, registered straight into oData.
- FILL state:
  - oReady=1.
  - Counters: col c (0..TILE_WIDTH-1), row r (0..TILE_HEIGHT-1), tile x tx (0..IMG_WIDTH/TILE_WIDTH-1), tile y ty (0..IMG_HEIGHT/TILE_HEIGHT-1).
  - Write address = (ty*TILE_HEIGHT + r)*IMG_WIDTH + tx*TILE_WIDTH + c.
  - Counters advance only on an accepted write: c wraps to 0 and increments r; r wraps and increments tx; tx wraps and increments ty.
  - iValid while oReady=0 is ignored; no write, no counter change.
- FILL->DRAIN: the cycle after the last pixel is accepted (tx, ty, r, c all at max).
  - oReady=0 from that cycle onward.
  - Read address counter starts at 0.
- DRAIN state:
  - rd_en = (read addr <= last address) && (!oValid || iReady).
  - On rd_en: oData <= mem[read addr]; oValid <= 1; read addr increments.
  - Otherwise, if iReady: oValid <= 0.
  - With iReady held at 1, throughput is 1 pixel/cycle. First oValid=1 occurs 2 cycles after the last write handshake.
  - Backpressure: while oValid && !iReady, oData, oValid and oLast hold stable.
  - oLast=1 exactly when oData holds mem[IMG_WIDTH*IMG_HEIGHT-1].
- DRAIN->FILL: on the oValid && iReady && oLast transfer, the next cycle has oValid=0, oFrameDone=1 (one cycle), state=FILL, oReady=1, and all counters at 0. A pixel may be accepted in that same cycle.
- Widths:
  - Address width = clog2(IMG_WIDTH*IMG_HEIGHT).
  - Counter widths = clog2 of their ranges, minimum 1.
  - No arithmetic overflow is permitted; wraps occur only at the max values listed above.

Test Plan:
- Defaults, in-order frame: feed 512 pixels with iData = index mod 256 and iReady=1.
  - Expect raster output #0=0x00, #15=0x0F, #16=0x00 (input 256), #17=0x01, #32=0x10, #511=0xFF with oLast=1.
  - Expect exactly 512 transfers, then one oFrameDone pulse.
- Latency: last write accepted at cycle N -> oReady=0 at N+1, oValid=1 with oData=mem[0] at N+2.
- Backpressure: during DRAIN hold iReady=0 for 5 cycles at raster pixel 100 -> oData stays at pixel 100's value and oValid stays 1; no pixel is skipped or duplicated; totals stay at 512.
- Input gaps: toggle iValid randomly (about 50%) during FILL -> raster output is identical to the in-order frame result.
- Reset mid-operation: assert iRst after 300 accepted pixels -> outputs are 0 immediately and oReady=1 after release. A fresh 512-pixel frame then produces correct raster output. Repeat with reset at raster output 200.
- Back-to-back frames: after oFrameDone, feed a second frame with iData = 0xFF - (index mod 256) -> output #0=0xFF, #16=0xFF, #511=0x00 with oLast=1.
